// File: rtl/rca_pkg.sv
// Shared constants and result type for the pipelined ripple-carry adder
// and the stages that consume its output.
package rca_pkg;

   localparam int RCA_WIDTH   = 4;
   localparam int RCA_LATENCY = 2;

   typedef logic [RCA_WIDTH:0] rca_result_t;

endpackage

// File: rtl/rca_result_buffer_sync_fifo.sv
// First-word fall-through circular FIFO with occupancy count and a sticky
// overflow flag; pointers wrap explicitly so any DEPTH >= 1 works.
module sync_fifo #(
   parameter int  DATA_W = 5,
   parameter int  DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              ovf
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              push_ok;
   logic              pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
         if (push && !push_ok) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rca_result_buffer.sv
// Result stage behind the pipelined adder: tracks issued operations through
// the adder latency, buffers their results and hands out issue credits.
module rca_result_buffer
   import rca_pkg::*;
#(
   parameter int  WIDTH   = RCA_WIDTH,
   parameter int  LATENCY = RCA_LATENCY,
   parameter int  DEPTH   = 4,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] res_sum,
   input  logic             res_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   output logic [CNT_W-1:0] count,
   output logic             err_ovf
);

   localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

   logic [LATENCY-1:0] vpipe;
   logic [SUM_W-1:0]   inflight;
   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + SUM_W'(vpipe[i]);
   end

   // Credits cover both buffered and in-flight results, so a push never finds the FIFO full.
   assign in_ready  = ~fifo_full && ((SUM_W'(count) + inflight) < SUM_W'(DEPTH));
   assign accept    = in_valid & in_ready;
   assign push      = vpipe[LATENCY-1];
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;

   // Valid delay line: one bit per adder issue slot
   always_ff @(posedge clk) begin
      if (rst) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= accept;
         for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
      end
   end

   sync_fifo #(
      .DATA_W (WIDTH + 1),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({res_cout, res_sum}),
      .pop   (pop),
      .dout  (out_data),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty),
      .ovf   (err_ovf)
   );

endmodule

// File: tb/tb_rca_result_buffer.sv
// Bench for rca_result_buffer: a behavioural 2-stage adder feeds the DUT and a
// queue-based reference model predicts credits, occupancy and result order.
module tb_rca_result_buffer;
   import rca_pkg::*;

   localparam int DEPTH = 4;
   localparam int LAT   = RCA_LATENCY;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [3:0]       a = '0;
   logic [3:0]       b = '0;
   logic             cin = 1'b0;
   logic [3:0]       res_sum;
   logic             res_cout;
   logic             in_ready;
   logic             out_valid;
   logic [4:0]       out_data;
   logic [2:0]       count;
   logic             err_ovf;

   always #5 clk = ~clk;

   // Adder: operands sampled at one edge, result stable after the next
   logic [8:0] s1;
   always @(posedge clk) begin
      s1 <= {a, b, cin};
      {res_cout, res_sum} <= 5'(s1[8:5]) + 5'(s1[4:1]) + 5'(s1[0]);
   end

   rca_result_buffer #(.WIDTH(4), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .err_ovf   (err_ovf)
   );

   typedef struct {
      rca_result_t res;
      int          acc;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic        o_ir, o_ov, o_ovf;
   logic [4:0]  o_od;
   logic [2:0]  o_cnt;
   logic        e_ir, e_ov;
   logic [4:0]  e_od;
   logic [2:0]  e_cnt;

   // An accepted operation sits in the FIFO once LAT edges past its accept edge.
   function automatic int model_count();
      int n = 0;
      foreach (q[i]) if (q[i].acc + LAT < cyc) n++;
      return n;
   endfunction

   task automatic cycle(input logic iv, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic ordy, input logic trst);
      logic acc_now, pop_now;
      @(negedge clk);
      in_valid = iv; a = ta; b = tb_; cin = tc; out_ready = ordy; rst = trst;
      #1;
      o_ir = in_ready; o_ov = out_valid; o_od = out_data; o_cnt = count; o_ovf = err_ovf;
      e_cnt = 3'(model_count());
      e_ir  = (q.size() < DEPTH);
      e_ov  = (e_cnt != 0);
      e_od  = (q.size() != 0) ? q[0].res : 5'bx;
      acc_now = iv & in_ready & ~trst;
      pop_now = out_valid & ordy & ~trst;
      @(posedge clk);
      if (trst) begin
         q.delete();
      end else begin
         if (pop_now && e_cnt != 0) void'(q.pop_front());
         if (acc_now) q.push_back('{res: 5'(ta) + 5'(tb_) + 5'(tc), acc: cyc});
      end
      cyc++;
   endtask

   task automatic test_reset();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      n_cmp += 4;
      if (o_cnt !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_cnt); end
      if (o_ov !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", o_ov); end
      if (o_ir !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", o_ir); end
      if (o_ovf !== 1'b0) begin n_err++; $display("FAIL reset_err_ovf got=%b exp=0", o_ovf); end
   endtask

   task automatic test_single();
      cycle(1, 4'b1001, 4'b1011, 0, 1, 0);
      n_cmp++;
      if (o_ir !== 1'b1) begin n_err++; $display("FAIL single_in_ready got=%b exp=1", o_ir); end
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 4'($urandom), 4'($urandom), 1'($urandom), 1, 0);
         n_cmp++;
         if (o_ov !== (i == 3)) begin
            n_err++; $display("FAIL single_out_valid step=%0d got=%b exp=%b", i, o_ov, (i == 3));
         end
         if (i == 3) begin
            n_cmp++;
            if (o_od !== 5'b1_0100) begin n_err++; $display("FAIL single_data got=%b exp=10100", o_od); end
         end
      end
      n_cmp++;
      if (o_cnt !== 3'd0) begin n_err++; $display("FAIL single_count_after got=%0d exp=0", o_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] opa [4] = '{4'b1001, 4'b1011, 4'b1000, 4'b1100};
      logic [3:0] opb [4] = '{4'b1011, 4'b1010, 4'b1000, 4'b1001};
      logic       opc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [4:0] exp [4] = '{5'b1_0100, 5'b1_0110, 5'b1_0000, 5'b1_0110};
      logic [4:0] got [$];
      int         idx [$];
      for (int i = 0; i < 10; i++) begin
         if (i < 4) cycle(1, opa[i], opb[i], opc[i], 1, 0);
         else       cycle(0, 4'($urandom), 4'($urandom), 0, 1, 0);
         if (i < 4) begin
            n_cmp++;
            if (o_ir !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready op=%0d got=%b exp=1", i, o_ir); end
         end
         if (o_ov === 1'b1) begin got.push_back(o_od); idx.push_back(i); end
      end
      n_cmp++;
      if (got.size() != 4) begin
         n_err++; $display("FAIL b2b_result_count got=%0d exp=4", got.size());
      end else begin
         n_cmp++;
         if (idx[0] != 3) begin n_err++; $display("FAIL b2b_first_cycle got=%0d exp=3", idx[0]); end
         for (int k = 0; k < 4; k++) begin
            n_cmp += 2;
            if (got[k] !== exp[k]) begin
               n_err++; $display("FAIL b2b_data k=%0d got=%b exp=%b", k, got[k], exp[k]);
            end
            if (idx[k] != idx[0] + k) begin
               n_err++; $display("FAIL b2b_consecutive k=%0d got=%0d exp=%0d", k, idx[k], idx[0] + k);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1, 4'($urandom), 4'($urandom), 1'($urandom), 0, 0);
         if (o_ir) n_acc++;
         n_cmp += 2;
         if (o_ir !== (i < 4)) begin n_err++; $display("FAIL bp_in_ready i=%0d got=%b exp=%b", i, o_ir, (i < 4)); end
         if (o_ir !== e_ir)    begin n_err++; $display("FAIL bp_in_ready_model i=%0d got=%b exp=%b", i, o_ir, e_ir); end
      end
      n_cmp++;
      if (n_acc != 4) begin n_err++; $display("FAIL bp_accepts got=%0d exp=4", n_acc); end
      cycle(0, 0, 0, 0, 0, 0);
      n_cmp += 3;
      if (o_cnt !== 3'd4) begin n_err++; $display("FAIL bp_count got=%0d exp=4", o_cnt); end
      if (o_ovf !== 1'b0) begin n_err++; $display("FAIL bp_err_ovf got=%b exp=0", o_ovf); end
      if (o_ir !== 1'b0)  begin n_err++; $display("FAIL bp_in_ready_hold got=%b exp=0", o_ir); end
   endtask

   task automatic test_drain();
      cycle(0, 0, 0, 0, 1, 0);
      n_cmp += 2;
      if (o_ov !== 1'b1) begin n_err++; $display("FAIL drain_pop_valid got=%b exp=1", o_ov); end
      if (o_od !== e_od) begin n_err++; $display("FAIL drain_pop_data got=%b exp=%b", o_od, e_od); end
      cycle(1, 4'b0111, 4'b0110, 1, 0, 0);
      n_cmp++;
      if (o_ir !== 1'b1) begin n_err++; $display("FAIL drain_credit got=%b exp=1", o_ir); end
      cycle(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (o_ir !== 1'b0) begin n_err++; $display("FAIL drain_credit_used got=%b exp=0", o_ir); end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 4'($urandom), 4'($urandom), 0, (i >= 2), 0);
         n_cmp += 3;
         if (o_cnt > 3'd4)   begin n_err++; $display("FAIL drain_count_bound got=%0d exp<=4", o_cnt); end
         if (o_cnt !== e_cnt) begin n_err++; $display("FAIL drain_count got=%0d exp=%0d", o_cnt, e_cnt); end
         if (o_ov !== e_ov)  begin n_err++; $display("FAIL drain_valid got=%b exp=%b", o_ov, e_ov); end
         if (e_ov) begin
            n_cmp++;
            if (o_od !== e_od) begin n_err++; $display("FAIL drain_order got=%b exp=%b", o_od, e_od); end
         end
      end
   endtask

   task automatic test_reset_midflight();
      cycle(1, 4'b0011, 4'b0100, 0, 0, 0);
      cycle(1, 4'b1111, 4'b0001, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 4'($urandom), 4'($urandom), 0, 1, 0);
         n_cmp += 3;
         if (o_ov !== 1'b0)  begin n_err++; $display("FAIL rstmid_valid i=%0d got=%b exp=0", i, o_ov); end
         if (o_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_count i=%0d got=%0d exp=0", i, o_cnt); end
         if (o_ir !== 1'b1)  begin n_err++; $display("FAIL rstmid_in_ready i=%0d got=%b exp=1", i, o_ir); end
      end
   endtask

   task automatic test_soak();
      int bias_v, bias_r, bad = 0;
      for (int i = 0; i < 10000; i++) begin
         if (i % 500 == 0) begin bias_v = $urandom_range(1, 9); bias_r = $urandom_range(1, 9); end
         cycle(($urandom_range(0, 9) < bias_v), 4'($urandom), 4'($urandom), 1'($urandom),
               ($urandom_range(0, 9) < bias_r), 0);
         n_cmp += 4;
         if (o_ir !== e_ir)   begin n_err++; bad++; if (bad < 10) $display("FAIL soak_in_ready cyc=%0d got=%b exp=%b", cyc, o_ir, e_ir); end
         if (o_cnt !== e_cnt) begin n_err++; bad++; if (bad < 10) $display("FAIL soak_count cyc=%0d got=%0d exp=%0d", cyc, o_cnt, e_cnt); end
         if (o_ov !== e_ov)   begin n_err++; bad++; if (bad < 10) $display("FAIL soak_valid cyc=%0d got=%b exp=%b", cyc, o_ov, e_ov); end
         if (o_ovf !== 1'b0)  begin n_err++; bad++; if (bad < 10) $display("FAIL soak_err_ovf cyc=%0d got=%b exp=0", cyc, o_ovf); end
         if (e_ov) begin
            n_cmp++;
            if (o_od !== e_od) begin n_err++; bad++; if (bad < 10) $display("FAIL soak_data cyc=%0d got=%b exp=%b", cyc, o_od, e_od); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_drain();
      test_reset_midflight();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rca_result_buffer.md
Name: rca_result_buffer

Overview:
- Downstream companion stage to the 2-stage pipelined 4-bit ripple-carry adder.
- Tracks which adder issue slots carry real operations by delaying a valid bit to match the adder latency. Captures the matching {cout,sum} into a small FIFO and presents results over a valid/ready interface.
- Drives a credit-style in_ready to the operand source, so an accepted operation always has a FIFO slot when it emerges.
- The adder itself has no stall. Flow control therefore happens only at issue.

Parameters:
- WIDTH, 4, adder operand width; stored entry width is WIDTH+1 ({cout,sum}).
- LATENCY, 2, number of rising clk edges from adder operand sampling to a stable result.
- DEPTH, 4, FIFO entries; must be >= 1.

Ports:
- clk  input  1  rising-edge clock, shared with the adder.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  source presents a, b, cin to the adder this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- res_sum  input  WIDTH  adder sum output.
- res_cout  input  1  adder cout output.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH+1  {cout,sum} of the oldest buffered result.
- count  output  clog2(DEPTH+1)  FIFO occupancy.
- err_ovf  output  1  sticky flag: a write was attempted while the FIFO was full.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FIFO: count=0, read and write pointers=0, out_valid=0.
  - vpipe (valid delay line): all bits 0.
  - err_ovf=0.
  - in_ready=1 after reset, because it is derived from count and vpipe.
  - out_data is don't-care while out_valid=0.
- Issue:
  - accept = in_valid & in_ready.
  - The source drives a, b, cin to the adder in the same cycle; the adder samples them at that edge.
  - inflight = popcount(vpipe).
  - in_ready = (count + inflight) < DEPTH. This is combinational from registers only, with no path from in_valid or out_ready.
- Valid pipe:
  - vpipe is LATENCY bits long and shifts every cycle without stalling.
  - At each edge: vpipe[0] <= accept; vpipe[i] <= vpipe[i-1].
  - push = vpipe[LATENCY-1]. In that cycle res_sum/res_cout hold the result of the operation accepted LATENCY-1 edges earlier.
  - The block samples {res_cout,res_sum} into the FIFO at the next edge. An operation accepted at edge N is therefore written at edge N+LATENCY.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH. Non-power-of-2 DEPTH wraps explicitly at DEPTH-1.
  - Reads are first-word fall-through: out_data = mem[rd_ptr] and out_valid = (count != 0).
  - pop = out_valid & out_ready.
  - Into an empty FIFO, out_valid rises directly after write edge N+LATENCY. Minimum accept-to-out_valid latency is LATENCY edges.
- Simultaneous events:
  - push & pop together: count is unchanged and both pointers advance, including when count==DEPTH.
  - push while count==DEPTH and no pop: the data is dropped, count is unchanged, err_ovf <= 1. The credit rule makes this unreachable; it is a checker target.
  - pop while empty is ignored.
- Backpressure: with out_ready held low, at most DEPTH operations are accepted and in_ready stays 0 until a pop. Each pop frees one credit at the next edge.
- Reset mid-operation:
  - In-flight vpipe bits are cleared and buffered results are discarded.
  - Adder results emerging after reset are never pushed.
- Ordering: results leave the block strictly in issue order.

Decomposition:
- Shared package rca_pkg holds:
  - constants RCA_WIDTH=4 and RCA_LATENCY=2;
  - a typedef for the {cout,sum} result, rca_result_t with WIDTH+1 bits.
- One sub-module is natural: sync_fifo, parameterised by data width and depth, with push/pop/count/full/empty/ovf.
- The top level holds vpipe, the popcount, and the credit logic.

Test Plan:
- Single op: accept 1001+1011+0 with out_ready=1 -> out_valid=1 two edges after accept, out_data=5'b1_0100, then count=0.
- Back-to-back stream: four ops on consecutive cycles (1001+1011+0, 1011+1010+1, 1000+1000+0, 1100+1001+1) with out_ready=1 -> out_data sequence 1_0100, 1_0110, 1_0000, 1_0110 on consecutive cycles.
- Backpressure: out_ready=0, in_valid=1 for 8 cycles -> exactly 4 accepts, in_ready=0 from the 4th accept onward, count reaches 4, err_ovf stays 0.
- Drain with simultaneous push/pop: with the FIFO full, raise out_ready for 1 cycle, then issue 1 op -> in_ready returns to 1 for one cycle, order preserved, count never exceeds 4.
- Reset mid-flight: accept 2 ops, assert rst on the following edge -> count=0, out_valid=0, vpipe=0, and no results appear afterwards.
- Random soak: random in_valid/out_ready over 10k cycles against a scoreboard computing a+b+cin -> zero mismatches, err_ovf=0.
